input_check: RTL and testbench
==============================

INPUT_CHECK -- requirements
Module: input_check

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000000, the idle cycles allowed between accepted keys before failure.
REQ-002 SHALL have parameter NUM_DIGITS, default 5, the maximum number of sequence digits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port seq  input  20  generated sequence; digit i at bits [4i+3:4i], digit 0 entered first.
REQ-006 SHALL have port curLvl  input  3  current level, equal to the number of digits to enter.
REQ-007 SHALL have port displayDone  input  1  one-cycle pulse marking the end of sequence display.
REQ-008 SHALL have port new_seq  input  1  one-cycle pulse marking that a new sequence was generated (abort).
REQ-009 SHALL have port key_valid  input  1  one-cycle pulse marking that key_digit is valid.
REQ-010 SHALL have port key_digit  input  4  player-entered digit.
REQ-011 SHALL have port entering  output  1  high while player entry is open.
REQ-012 SHALL have port digitIdx  output  3  index of the next expected digit.
REQ-013 SHALL have port digitOk  output  1  one-cycle pulse for a correct non-final digit.
REQ-014 SHALL have port lvlPass  output  1  one-cycle pulse when all digits are entered correctly.
REQ-015 SHALL have port lvlFail  output  1  one-cycle pulse on a wrong digit or a timeout.
REQ-016 SHALL have port timedOut  output  1  high together with lvlFail when the failure cause is timeout.

Function
REQ-017 SHALL implement states IDLE, WAIT_KEY, PASS and FAIL.
REQ-018 In IDLE, a displayDone pulse SHALL snapshot seq and the target count, clear digitIdx and the timer, and move to WAIT_KEY.
REQ-019 The target count SHALL be curLvl clamped to 1..NUM_DIGITS: a value of 0 is treated as 1, and values 6 and 7 are treated as 5.
REQ-020 In WAIT_KEY, entering SHALL be 1; in every other state it SHALL be 0.
REQ-021 In WAIT_KEY, key_valid with a matching, non-final digit SHALL increment digitIdx, pulse digitOk in the next cycle, and clear the timer.
REQ-022 In WAIT_KEY, key_valid with a matching digit where digitIdx = target-1 SHALL move to PASS.
REQ-023 In WAIT_KEY, key_valid with a mismatching digit SHALL move to FAIL.
REQ-024 In WAIT_KEY, the timer SHALL increment on every cycle with no key_valid; on reaching TIMEOUT_CYCLES-1, the block SHALL move to FAIL with timedOut set.
REQ-025 PASS SHALL assert lvlPass for exactly one cycle and then return to IDLE; FAIL SHALL assert lvlFail (plus timedOut if applicable) for exactly one cycle and then return to IDLE.
REQ-026 Latency from the key_valid edge to digitOk, lvlPass or lvlFail SHALL be exactly 1 cycle; all outputs SHALL be registered.
REQ-027 key_valid in IDLE, PASS or FAIL SHALL be ignored, as SHALL displayDone outside IDLE.
REQ-028 new_seq in WAIT_KEY SHALL return the block to IDLE with no pass or fail pulse; new_seq SHALL take priority over a simultaneous key_valid.
REQ-029 A key_valid coinciding with timer expiry SHALL be evaluated as a key, not as a timeout.
REQ-030 Changes to seq or curLvl during WAIT_KEY SHALL have no effect, because comparisons use the snapshot.
REQ-031 The timer width SHALL be $clog2(TIMEOUT_CYCLES), and the timer SHALL saturate rather than wrap.

Reset
REQ-032 While rst=0, the block SHALL immediately force: state IDLE; digitIdx, timer and snapshot to 0; and all outputs to 0.
REQ-033 Reset asserted mid-entry SHALL abort the entry without emitting a pass or fail pulse.
REQ-034 After rst deasserts, the block SHALL accept displayDone on the first clock edge.

Structure
REQ-035 A shared package SHALL hold the state enumeration, DIGIT_W=4, NUM_DIGITS=5 and SEQ_W=20.
REQ-036 The timeout counter SHALL be a sub-module entry_timer, with inputs clear and enable and output expired.
REQ-037 The digit select SHALL be a combinational multiplexer from the snapshot indexed by digitIdx.

Verification
REQ-038 Scenario (full pass): seq=20'h47193, curLvl=5, displayDone, then keys 3,9,1,7,4 -> four digitOk pulses, then lvlPass 1 cycle after the fifth key, with entering=0.
REQ-039 Scenario (mismatch): same seq, curLvl=3, keys 3,9,5 -> lvlFail with timedOut=0 one cycle after key 5, and digitIdx returns to 0.
REQ-040 Scenario (timeout): TIMEOUT_CYCLES=16, curLvl=2, key 3, then no keys -> lvlFail with timedOut=1 exactly 15 cycles after the digitOk-triggering key.
REQ-041 Scenario (abort and ignore): new_seq together with key_valid in WAIT_KEY -> no pulses and entering=0; key_valid in IDLE -> no response.
REQ-042 Scenario (clamp and snapshot): curLvl=0 with key 3 -> lvlPass; changing seq mid-entry with curLvl=2 and keys 3,9 -> lvlPass.
REQ-043 Scenario (reset mid-entry): rst=0 asynchronously after the second key -> outputs become 0 immediately and no lvlPass/lvlFail follows.

Source files
------------

// File: rtl/input_check_pkg.sv
// Shared types and constants for the player key-entry checker.
package input_check_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 5;
    localparam int unsigned SEQ_W      = 20;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_KEY,
        PASS,
        FAIL
    } state_t;

    // Level 0 still means one digit; anything above the supported depth is capped.
    function automatic logic [2:0] clamp_level(input logic [2:0] lvl,
                                               input int unsigned max_digits);
        if (lvl == 3'd0)
            return 3'd1;
        if (32'(lvl) > max_digits)
            return 3'(max_digits);
        return lvl;
    endfunction

endpackage

// File: rtl/input_check_entry_timer.sv
// Idle-cycle counter for key entry; saturates at TIMEOUT_CYCLES-1.
module entry_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && (count != LIMIT))
            count <= count + 1'b1;
    end

    // Flags the idle cycle whose increment reaches LIMIT, so the FSM fails on that same edge.
    assign expired = enable && !clear && (count >= (LIMIT - 1'b1));

endmodule

// File: rtl/input_check.sv
// Checks player key entry against a snapshot of the displayed sequence.
module input_check
    import input_check_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned NUM_DIGITS     = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEQ_W-1:0]    seq,
    input  logic [2:0]          curLvl,
    input  logic                displayDone,
    input  logic                new_seq,
    input  logic                key_valid,
    input  logic [DIGIT_W-1:0]  key_digit,
    output logic                entering,
    output logic [2:0]          digitIdx,
    output logic                digitOk,
    output logic                lvlPass,
    output logic                lvlFail,
    output logic                timedOut
);

    localparam int unsigned SLOTS      = SEQ_W / DIGIT_W;
    localparam int unsigned MAX_DIGITS = (NUM_DIGITS < SLOTS) ? NUM_DIGITS : SLOTS;

    state_t               state;
    logic [SEQ_W-1:0]     snapshot;
    logic [2:0]           target;
    logic [DIGIT_W-1:0]   expected_digit;
    logic                 timer_clear;
    logic                 timer_en;
    logic                 expired;

    always_comb begin
        expected_digit = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (digitIdx == 3'(i))
                expected_digit = snapshot[i*DIGIT_W +: DIGIT_W];
        end
    end

    assign timer_clear = (state != WAIT_KEY) || key_valid;
    assign timer_en    = (state == WAIT_KEY) && !key_valid;

    entry_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            snapshot <= '0;
            target   <= '0;
            entering <= 1'b0;
            digitIdx <= '0;
            digitOk  <= 1'b0;
            lvlPass  <= 1'b0;
            lvlFail  <= 1'b0;
            timedOut <= 1'b0;
        end else begin
            digitOk  <= 1'b0;
            lvlPass  <= 1'b0;
            lvlFail  <= 1'b0;
            timedOut <= 1'b0;
            case (state)
                IDLE: begin
                    entering <= 1'b0;
                    if (displayDone) begin
                        snapshot <= seq;
                        target   <= clamp_level(curLvl, MAX_DIGITS);
                        digitIdx <= '0;
                        entering <= 1'b1;
                        state    <= WAIT_KEY;
                    end
                end
                WAIT_KEY: begin
                    // Abort wins over a key arriving on the same edge; a key wins over timeout.
                    if (new_seq) begin
                        entering <= 1'b0;
                        digitIdx <= '0;
                        state    <= IDLE;
                    end else if (key_valid) begin
                        if (key_digit != expected_digit) begin
                            lvlFail  <= 1'b1;
                            entering <= 1'b0;
                            digitIdx <= '0;
                            state    <= FAIL;
                        end else if (digitIdx == (target - 3'd1)) begin
                            lvlPass  <= 1'b1;
                            entering <= 1'b0;
                            digitIdx <= '0;
                            state    <= PASS;
                        end else begin
                            digitOk  <= 1'b1;
                            digitIdx <= digitIdx + 3'd1;
                        end
                    end else if (expired) begin
                        lvlFail  <= 1'b1;
                        timedOut <= 1'b1;
                        entering <= 1'b0;
                        digitIdx <= '0;
                        state    <= FAIL;
                    end
                end
                PASS, FAIL: begin
                    entering <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    entering <= 1'b0;
                    digitIdx <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_check.sv
// Self-checking bench for input_check: cycle model plus directed scenarios.
module tb_input_check;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] seq;
    logic [2:0]  curLvl;
    logic        displayDone, new_seq, key_valid;
    logic [3:0]  key_digit;
    logic        entering, digitOk, lvlPass, lvlFail, timedOut;
    logic [2:0]  digitIdx;

    int checks = 0;
    int failures = 0;

    input_check #(
        .TIMEOUT_CYCLES(TO),
        .NUM_DIGITS(5)
    ) dut (
        .clk(clk), .rst(rst), .seq(seq), .curLvl(curLvl),
        .displayDone(displayDone), .new_seq(new_seq),
        .key_valid(key_valid), .key_digit(key_digit),
        .entering(entering), .digitIdx(digitIdx), .digitOk(digitOk),
        .lvlPass(lvlPass), .lvlFail(lvlFail), .timedOut(timedOut)
    );

    always #5 clk = ~clk;

    // Behavioural model: entry open/closed, digit list, idle-cycle count.
    bit m_open, m_cool;
    int m_idx, m_tgt, m_idle;
    int m_snap [5];
    bit e_ok, e_pass, e_fail, e_to;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_open = 0; m_cool = 0; m_idx = 0; m_tgt = 0; m_idle = 0;
            e_ok = 0; e_pass = 0; e_fail = 0; e_to = 0;
            for (int i = 0; i < 5; i++) m_snap[i] = 0;
        end else begin
            e_ok = 0; e_pass = 0; e_fail = 0; e_to = 0;
            if (m_cool) begin
                m_cool = 0;
            end else if (!m_open) begin
                if (displayDone) begin
                    m_open = 1; m_idx = 0; m_idle = 0;
                    m_tgt = (curLvl == 0) ? 1 : ((curLvl > 5) ? 5 : int'(curLvl));
                    for (int i = 0; i < 5; i++) m_snap[i] = int'(seq[4*i +: 4]);
                end
            end else if (new_seq) begin
                m_open = 0; m_idx = 0;
            end else if (key_valid) begin
                m_idle = 0;
                if (int'(key_digit) == m_snap[m_idx]) begin
                    if (m_idx + 1 == m_tgt) begin
                        e_pass = 1; m_open = 0; m_idx = 0; m_cool = 1;
                    end else begin
                        e_ok = 1; m_idx = m_idx + 1;
                    end
                end else begin
                    e_fail = 1; m_open = 0; m_idx = 0; m_cool = 1;
                end
            end else begin
                m_idle = m_idle + 1;
                if (m_idle >= int'(TO) - 1) begin
                    e_fail = 1; e_to = 1; m_open = 0; m_idx = 0; m_cool = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_entering", int'(entering), int'(m_open));
        chk("cyc_digitIdx", int'(digitIdx), m_idx);
        chk("cyc_digitOk",  int'(digitOk),  int'(e_ok));
        chk("cyc_lvlPass",  int'(lvlPass),  int'(e_pass));
        chk("cyc_lvlFail",  int'(lvlFail),  int'(e_fail));
        chk("cyc_timedOut", int'(timedOut), int'(e_to));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_done();
        displayDone = 1'b1;
        @(negedge clk);
        displayDone = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        seq = '0; curLvl = '0; displayDone = 0; new_seq = 0; key_valid = 0; key_digit = '0;
        #1 rst = 1'b0;
        repeat (3) step();
        chk("rst_entering", int'(entering), 0);
        chk("rst_idx", int'(digitIdx), 0);
        chk("rst_pulses", int'({digitOk, lvlPass, lvlFail, timedOut}), 0);
        rst = 1'b1;
        step();

        // Full pass: digits 3,9,1,7,4
        seq = 20'h47193; curLvl = 3'd5;
        pulse_done();
        chk("s1_entering", int'(entering), 1);
        press(4'd3); chk("s1_ok1", int'(digitOk), 1); chk("s1_idx1", int'(digitIdx), 1);
        press(4'd9); chk("s1_ok2", int'(digitOk), 1);
        press(4'd1); chk("s1_ok3", int'(digitOk), 1);
        press(4'd7); chk("s1_ok4", int'(digitOk), 1); chk("s1_idx4", int'(digitIdx), 4);
        press(4'd4);
        chk("s1_pass", int'(lvlPass), 1);
        chk("s1_ok5", int'(digitOk), 0);
        chk("s1_entering_off", int'(entering), 0);
        step();
        chk("s1_pass_once", int'(lvlPass), 0);

        // Mismatch on third digit
        curLvl = 3'd3;
        pulse_done();
        press(4'd3); press(4'd9); press(4'd5);
        chk("s2_fail", int'(lvlFail), 1);
        chk("s2_to", int'(timedOut), 0);
        chk("s2_idx", int'(digitIdx), 0);
        step();
        chk("s2_fail_once", int'(lvlFail), 0);

        // Timeout 15 cycles after the accepted key
        curLvl = 3'd2;
        pulse_done();
        press(4'd3);
        chk("s3_ok", int'(digitOk), 1);
        n = 0;
        while (!lvlFail && n < 40) begin
            step();
            n++;
        end
        chk("s3_latency", n, 15);
        chk("s3_to", int'(timedOut), 1);
        step();

        // Abort with simultaneous key, then key in IDLE
        curLvl = 3'd3;
        pulse_done();
        new_seq = 1'b1; key_valid = 1'b1; key_digit = 4'd3;
        step();
        new_seq = 1'b0; key_valid = 1'b0;
        chk("s4_entering", int'(entering), 0);
        chk("s4_pulses", int'({digitOk, lvlPass, lvlFail}), 0);
        press(4'd3);
        chk("s4_idle_key", int'({digitOk, lvlPass, lvlFail, entering}), 0);
        step();

        // Clamp and snapshot
        curLvl = 3'd0;
        pulse_done();
        press(4'd3);
        chk("s5_clamp0_pass", int'(lvlPass), 1);
        step();
        curLvl = 3'd2;
        pulse_done();
        press(4'd3);
        seq = 20'hFFFFF; curLvl = 3'd5;
        press(4'd9);
        chk("s5_snap_pass", int'(lvlPass), 1);
        step();
        seq = 20'h47193; curLvl = 3'd7;
        pulse_done();
        press(4'd3); press(4'd9); press(4'd1); press(4'd7);
        chk("s5_clamp7_open", int'(entering), 1);
        press(4'd4);
        chk("s5_clamp7_pass", int'(lvlPass), 1);
        step();

        // Asynchronous reset mid-entry
        curLvl = 3'd5;
        pulse_done();
        press(4'd3); press(4'd9);
        chk("s6_pre_ok", int'(digitOk), 1);
        #2 rst = 1'b0;
        #1;
        chk("s6_async_entering", int'(entering), 0);
        chk("s6_async_idx", int'(digitIdx), 0);
        chk("s6_async_ok", int'(digitOk), 0);
        step(); step();
        rst = 1'b1;
        n = 0;
        repeat (20) begin
            step();
            if (lvlPass || lvlFail) n++;
        end
        chk("s6_no_result", n, 0);

        // displayDone on first edge after reset release
        rst = 1'b0;
        step();
        rst = 1'b1;
        pulse_done();
        chk("s7_accept", int'(entering), 1);
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
